// File: rtl/connector_pkg.sv
// Shared types and constants for the trace-encoder connector.
// Contents:
//   - width constants XLEN, IRETIRE_LEN, ITYPE_LEN, PRIV_LEN
//   - itype codes
//   - uop_entry_s: one retired uop lane
//   - exc_info_s: exception cause/tval
//   - block_entry_s: one aggregated instruction block
//   - agg_state_e: block aggregator state
//   - scan_event_e: lane scanner result kind
//   - iretire_inc(): halfword increment of one instruction
package connector_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned IRETIRE_LEN = 14;
    localparam int unsigned ITYPE_LEN   = 4;
    localparam int unsigned PRIV_LEN    = 2;

    localparam logic [ITYPE_LEN-1:0] ItypeStd  = ITYPE_LEN'(0);
    localparam logic [ITYPE_LEN-1:0] ItypeExc  = ITYPE_LEN'(1);
    localparam logic [ITYPE_LEN-1:0] ItypeInt  = ITYPE_LEN'(2);
    localparam logic [ITYPE_LEN-1:0] ItypeEret = ITYPE_LEN'(3);
    localparam logic [ITYPE_LEN-1:0] ItypeNtb  = ITYPE_LEN'(4);
    localparam logic [ITYPE_LEN-1:0] ItypeTb   = ITYPE_LEN'(5);
    localparam logic [ITYPE_LEN-1:0] ItypeCall = ITYPE_LEN'(6);
    localparam logic [ITYPE_LEN-1:0] ItypeRet  = ITYPE_LEN'(7);

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } exc_info_s;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [ITYPE_LEN-1:0] itype;
        logic [PRIV_LEN-1:0]  priv;
        logic                 compressed;
    } uop_entry_s;

    typedef struct packed {
        logic [XLEN-1:0]        iaddr;
        logic [IRETIRE_LEN-1:0] iretire;
        logic [ITYPE_LEN-1:0]   itype;
        logic [PRIV_LEN-1:0]    priv;
        logic                   ilastsize;
        exc_info_s              exc;
    } block_entry_s;

    typedef enum logic [0:0] {StIdle, StCount} agg_state_e;

    typedef enum logic [1:0] {EvNone, EvTerm, EvSplit} scan_event_e;

    function automatic logic [1:0] iretire_inc(input logic compressed);
        return compressed ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/te_block_aggregator_scanner.sv
// Combinational lane scanner for the block aggregator.
// Walks the valid lanes of a beat starting at lane pointer lp and stops at the
// first lane that either terminates the block or forces a split.
// Ports:
//   lanes      in   NRET uop lanes (valid bits contiguous from lane 0)
//   lp         in   first lane still to be consumed
//   state      in   aggregator state (a block is open in StCount)
//   blk_priv   in   privilege of the open block
//   count      in   halfword count of the open block
//   kind       out  EvNone / EvTerm / EvSplit
//   k          out  event lane index
//   sum        out  halfwords added by the lanes included in the block
//   last       out  no event, or the event lane is the last valid lane
//   any_valid  out  at least one lane is valid
//   lastsize   out  compressed flag of the last included lane (when sum != 0)
module te_lane_scanner #(
    parameter int unsigned NRET        = 2,
    parameter int unsigned IRETIRE_LEN = connector_pkg::IRETIRE_LEN,
    parameter int unsigned PRIV_LEN    = connector_pkg::PRIV_LEN,
    localparam int unsigned LpW        = (NRET > 1) ? $clog2(NRET) : 1
) (
    input  connector_pkg::uop_entry_s [NRET-1:0] lanes,
    input  logic [LpW-1:0]                       lp,
    input  connector_pkg::agg_state_e            state,
    input  logic [PRIV_LEN-1:0]                  blk_priv,
    input  logic [IRETIRE_LEN-1:0]               count,
    output connector_pkg::scan_event_e           kind,
    output logic [LpW-1:0]                       k,
    output logic [IRETIRE_LEN-1:0]               sum,
    output logic                                 last,
    output logic                                 any_valid,
    output logic                                 lastsize
);
    import connector_pkg::*;

    // One extra bit so count + inc cannot wrap before the saturation compare.
    localparam int unsigned CntW = IRETIRE_LEN + 1;
    localparam logic [CntW-1:0] CntMax = CntW'({IRETIRE_LEN{1'b1}});

    logic                open;
    logic                done;
    logic [PRIV_LEN-1:0] run_priv;
    logic [CntW-1:0]     run_cnt;
    logic [CntW-1:0]     inc;
    logic [LpW-1:0]      last_idx;

    always_comb begin
        kind      = EvNone;
        k         = '0;
        sum       = '0;
        lastsize  = 1'b0;
        any_valid = 1'b0;
        last_idx  = '0;
        open      = (state == StCount);
        done      = 1'b0;
        run_priv  = blk_priv;
        run_cnt   = {1'b0, count};
        inc       = '0;
        for (int i = 0; i < NRET; i++) begin
            if (lanes[i].valid) begin
                any_valid = 1'b1;
                last_idx  = LpW'(i);
            end
            if (!done && lanes[i].valid && (i >= int'(lp))) begin
                inc = CntW'(iretire_inc(lanes[i].compressed));
                if (open && ((lanes[i].priv != run_priv) || (run_cnt + inc > CntMax))) begin
                    kind = EvSplit;
                    k    = LpW'(i);
                    done = 1'b1;
                end else begin
                    if (!open) begin
                        open     = 1'b1;
                        run_priv = lanes[i].priv;
                        run_cnt  = '0;
                    end
                    run_cnt  = run_cnt + inc;
                    sum      = sum + IRETIRE_LEN'(inc);
                    lastsize = lanes[i].compressed;
                    if (lanes[i].itype != ItypeStd) begin
                        kind = EvTerm;
                        k    = LpW'(i);
                        done = 1'b1;
                    end
                end
            end
        end
        last = (kind == EvNone) || (k == last_idx);
    end

endmodule

// File: rtl/te_block_aggregator.sv
// Retirement block aggregator: merges runs of STD uops from multi-lane beats
// into instruction blocks for the encoder packet stage.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   in_valid_i        input beat valid
//   in_ready_o        beat fully consumed this cycle (combinational)
//   in_uop_i          NRET uop lanes
//   in_exc_i          cause/tval for the EXC/INT lane of the beat
//   flush_i           force-close the open block
//   out_valid_o       block valid
//   out_ready_i       consumer accepts block
//   out_iaddr_o       pc of first instruction in block
//   out_iretire_o     block size in halfwords
//   out_itype_o       itype of the closing lane, STD on split/flush
//   out_priv_o        block privilege
//   out_ilastsize_o   last instruction compressed
//   out_cause_o       cause for EXC/INT blocks, else 0
//   out_tval_o        tval for EXC/INT blocks, else 0
module te_block_aggregator #(
    parameter int unsigned NRET        = 2,
    parameter int unsigned XLEN        = connector_pkg::XLEN,
    parameter int unsigned IRETIRE_LEN = connector_pkg::IRETIRE_LEN,
    parameter int unsigned ITYPE_LEN   = connector_pkg::ITYPE_LEN,
    parameter int unsigned PRIV_LEN    = connector_pkg::PRIV_LEN
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  connector_pkg::uop_entry_s [NRET-1:0] in_uop_i,
    input  connector_pkg::exc_info_s             in_exc_i,
    input  logic                                 flush_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [XLEN-1:0]                      out_iaddr_o,
    output logic [IRETIRE_LEN-1:0]               out_iretire_o,
    output logic [ITYPE_LEN-1:0]                 out_itype_o,
    output logic [PRIV_LEN-1:0]                  out_priv_o,
    output logic                                 out_ilastsize_o,
    output logic [XLEN-1:0]                      out_cause_o,
    output logic [XLEN-1:0]                      out_tval_o
);
    import connector_pkg::*;

    localparam int unsigned LpW = (NRET > 1) ? $clog2(NRET) : 1;

    agg_state_e             state_q, state_d;
    logic [LpW-1:0]         lp_q, lp_d;
    logic [XLEN-1:0]        iaddr_q, iaddr_d;
    logic [PRIV_LEN-1:0]    priv_q, priv_d;
    logic [IRETIRE_LEN-1:0] count_q, count_d;
    logic                   lastsize_q, lastsize_d;

    logic                   out_valid_q;
    logic [XLEN-1:0]        out_iaddr_q, out_cause_q, out_tval_q;
    logic [IRETIRE_LEN-1:0] out_iretire_q;
    logic [ITYPE_LEN-1:0]   out_itype_q;
    logic [PRIV_LEN-1:0]    out_priv_q;
    logic                   out_ilastsize_q;

    scan_event_e            kind;
    logic [LpW-1:0]         k;
    logic [IRETIRE_LEN-1:0] sum;
    logic                   last, any_valid, scan_lastsize;

    logic                   slot_free;
    logic [XLEN-1:0]        new_iaddr;
    logic [PRIV_LEN-1:0]    new_priv;
    logic [IRETIRE_LEN-1:0] new_cnt;
    logic                   new_lastsize;

    logic                   emit;
    logic [IRETIRE_LEN-1:0] emit_iretire;
    logic [ITYPE_LEN-1:0]   emit_itype;
    logic                   emit_lastsize;
    logic [XLEN-1:0]        emit_cause, emit_tval;

    te_lane_scanner #(
        .NRET        (NRET),
        .IRETIRE_LEN (IRETIRE_LEN),
        .PRIV_LEN    (PRIV_LEN)
    ) u_scanner (
        .lanes     (in_uop_i),
        .lp        (lp_q),
        .state     (state_q),
        .blk_priv  (priv_q),
        .count     (count_q),
        .kind      (kind),
        .k         (k),
        .sum       (sum),
        .last      (last),
        .any_valid (any_valid),
        .lastsize  (scan_lastsize)
    );

    assign slot_free = !out_valid_q || out_ready_i;

    // In IDLE the lane at lp is always the one that opens the block.
    assign new_iaddr    = (state_q == StIdle) ? in_uop_i[lp_q].pc : iaddr_q;
    assign new_priv     = (state_q == StIdle) ? in_uop_i[lp_q].priv : priv_q;
    assign new_cnt      = ((state_q == StCount) ? count_q : '0) + sum;
    // A split on the first scanned lane closes with the lane seen in an earlier beat.
    assign new_lastsize = (sum != '0) ? scan_lastsize : lastsize_q;

    always_comb begin
        state_d       = state_q;
        lp_d          = lp_q;
        iaddr_d       = iaddr_q;
        priv_d        = priv_q;
        count_d       = count_q;
        lastsize_d    = lastsize_q;
        in_ready_o    = 1'b0;
        emit          = 1'b0;
        emit_iretire  = new_cnt;
        emit_itype    = ItypeStd;
        emit_lastsize = new_lastsize;
        emit_cause    = '0;
        emit_tval     = '0;
        if (flush_i) begin
            if ((state_q == StCount) && slot_free) begin
                emit          = 1'b1;
                emit_iretire  = count_q;
                emit_lastsize = lastsize_q;
                state_d       = StIdle;
            end
        end else if (in_valid_i) begin
            if (!any_valid) begin
                in_ready_o = 1'b1;
            end else begin
                unique case (kind)
                    EvNone: begin
                        state_d    = StCount;
                        lp_d       = '0;
                        iaddr_d    = new_iaddr;
                        priv_d     = new_priv;
                        count_d    = new_cnt;
                        lastsize_d = new_lastsize;
                        in_ready_o = 1'b1;
                    end
                    EvTerm: begin
                        if (slot_free) begin
                            emit       = 1'b1;
                            emit_itype = in_uop_i[k].itype;
                            if ((in_uop_i[k].itype == ItypeExc) ||
                                (in_uop_i[k].itype == ItypeInt)) begin
                                emit_cause = in_exc_i.cause;
                                emit_tval  = in_exc_i.tval;
                            end
                            state_d    = StIdle;
                            lp_d       = last ? '0 : k + LpW'(1);
                            in_ready_o = last;
                        end
                    end
                    EvSplit: begin
                        // Lane k stays pending and opens the next block.
                        if (slot_free) begin
                            emit    = 1'b1;
                            state_d = StIdle;
                            lp_d    = k;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            lp_q       <= '0;
            iaddr_q    <= '0;
            priv_q     <= '0;
            count_q    <= '0;
            lastsize_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lp_q       <= lp_d;
            iaddr_q    <= iaddr_d;
            priv_q     <= priv_d;
            count_q    <= count_d;
            lastsize_q <= lastsize_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q     <= 1'b0;
            out_iaddr_q     <= '0;
            out_iretire_q   <= '0;
            out_itype_q     <= '0;
            out_priv_q      <= '0;
            out_ilastsize_q <= 1'b0;
            out_cause_q     <= '0;
            out_tval_q      <= '0;
        end else if (emit) begin
            out_valid_q     <= 1'b1;
            out_iaddr_q     <= new_iaddr;
            out_iretire_q   <= emit_iretire;
            out_itype_q     <= emit_itype;
            out_priv_q      <= new_priv;
            out_ilastsize_q <= emit_lastsize;
            out_cause_q     <= emit_cause;
            out_tval_q      <= emit_tval;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign out_iaddr_o     = out_iaddr_q;
    assign out_iretire_o   = out_iretire_q;
    assign out_itype_o     = out_itype_q;
    assign out_priv_o      = out_priv_q;
    assign out_ilastsize_o = out_ilastsize_q;
    assign out_cause_o     = out_cause_q;
    assign out_tval_o      = out_tval_q;

endmodule

// File: tb/tb_te_block_aggregator.sv
// Self-checking bench for te_block_aggregator (NRET=2, IRETIRE_LEN=4).
// A stream-level reference model turns every uop sent into expected blocks;
// a monitor compares each accepted output block and checks output hold.
module tb_te_block_aggregator;
    import connector_pkg::*;

    localparam int unsigned NRET   = 2;
    localparam int unsigned IRL    = 4;
    localparam int          MAXCNT = (1 << IRL) - 1;

    typedef logic [127:0] blk_t;

    logic                  clk = 1'b0;
    logic                  rst, in_valid, in_ready, flush, out_valid, out_ready;
    uop_entry_s [NRET-1:0] in_uop;
    exc_info_s             in_exc;
    logic [XLEN-1:0]       out_iaddr, out_cause, out_tval;
    logic [IRL-1:0]        out_iretire;
    logic [ITYPE_LEN-1:0]  out_itype;
    logic [PRIV_LEN-1:0]   out_priv;
    logic                  out_ilastsize;

    always #5 clk = ~clk;

    te_block_aggregator #(
        .NRET        (NRET),
        .XLEN        (XLEN),
        .IRETIRE_LEN (IRL),
        .ITYPE_LEN   (ITYPE_LEN),
        .PRIV_LEN    (PRIV_LEN)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_uop_i        (in_uop),
        .in_exc_i        (in_exc),
        .flush_i         (flush),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_iaddr_o     (out_iaddr),
        .out_iretire_o   (out_iretire),
        .out_itype_o     (out_itype),
        .out_priv_o      (out_priv),
        .out_ilastsize_o (out_ilastsize),
        .out_cause_o     (out_cause),
        .out_tval_o      (out_tval)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input blk_t obs, input blk_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic blk_t pack_blk(input logic [XLEN-1:0] addr, input logic [IRL-1:0] cnt,
                                      input logic [ITYPE_LEN-1:0] it,
                                      input logic [PRIV_LEN-1:0] pr, input logic ls,
                                      input logic [XLEN-1:0] cause,
                                      input logic [XLEN-1:0] tval);
        return blk_t'({addr, cnt, it, pr, ls, cause, tval});
    endfunction

    // Reference model: walks the uop stream one instruction at a time.
    blk_t                exp_q[$];
    logic                m_open = 1'b0;
    logic [XLEN-1:0]     m_addr;
    logic [PRIV_LEN-1:0] m_priv;
    int                  m_cnt;
    logic                m_ls;

    function automatic void model_uop(input uop_entry_s u, input exc_info_s e);
        int   inc;
        logic is_exc;
        inc = u.compressed ? 1 : 2;
        if (m_open && ((u.priv != m_priv) || (m_cnt + inc > MAXCNT))) begin
            exp_q.push_back(pack_blk(m_addr, IRL'(m_cnt), ItypeStd, m_priv, m_ls, '0, '0));
            m_open = 1'b0;
        end
        if (!m_open) begin
            m_open = 1'b1;
            m_addr = u.pc;
            m_priv = u.priv;
            m_cnt  = 0;
        end
        m_cnt += inc;
        m_ls = u.compressed;
        if (u.itype != ItypeStd) begin
            is_exc = (u.itype == ItypeExc) || (u.itype == ItypeInt);
            exp_q.push_back(pack_blk(m_addr, IRL'(m_cnt), u.itype, m_priv, m_ls,
                                     is_exc ? e.cause : '0, is_exc ? e.tval : '0));
            m_open = 1'b0;
        end
    endfunction

    function automatic void model_flush();
        if (m_open) exp_q.push_back(pack_blk(m_addr, IRL'(m_cnt), ItypeStd, m_priv, m_ls, '0, '0));
        m_open = 1'b0;
    endfunction

    // Output monitor: scoreboard compare on handshake, stability under backpressure.
    initial begin
        blk_t cur;
        blk_t prev_out;
        logic prev_hold;
        prev_hold = 1'b0;
        prev_out  = '0;
        forever begin
            @(negedge clk);
            cur = pack_blk(out_iaddr, out_iretire, out_itype, out_priv, out_ilastsize,
                           out_cause, out_tval);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check_eq("hold_valid", out_valid, 1);
                    check_eq("hold_data", cur, prev_out);
                end
                if (flush) check_eq("flush_in_ready", in_ready, 0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check_eq("extra_block", cur, '0);
                    else check_eq("block", cur, exp_q.pop_front());
                end
                prev_hold = out_valid && !out_ready;
                prev_out  = cur;
            end
        end
    end

    int rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready

    task automatic cyc();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    endtask

    function automatic uop_entry_s mk(input logic v, input logic [XLEN-1:0] pc,
                                      input logic [ITYPE_LEN-1:0] it,
                                      input logic [PRIV_LEN-1:0] pr, input logic c);
        uop_entry_s u;
        u.valid      = v;
        u.pc         = pc;
        u.itype      = it;
        u.priv       = pr;
        u.compressed = c;
        return u;
    endfunction

    function automatic exc_info_s mk_exc(input logic [XLEN-1:0] c, input logic [XLEN-1:0] t);
        exc_info_s e;
        e.cause = c;
        e.tval  = t;
        return e;
    endfunction

    task automatic drive_beat(input uop_entry_s l0, input uop_entry_s l1, input exc_info_s e);
        in_uop[0] = l0;
        in_uop[1] = l1;
        in_exc    = e;
        in_valid  = 1'b1;
        if (l0.valid) begin
            model_uop(l0, e);
            if (l1.valid) model_uop(l1, e);
        end
    endtask

    task automatic wait_accept(input string tag);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 500 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        if (!acc) check_eq({tag, "_accept_timeout"}, acc, 1);
    endtask

    task automatic send(input uop_entry_s l0, input uop_entry_s l1, input exc_info_s e,
                        input string tag);
        drive_beat(l0, l1, e);
        wait_accept(tag);
    endtask

    task automatic do_flush();
        flush     = 1'b1;
        out_ready = 1'b1;
        model_flush();
        cyc();
        flush = 1'b0;
    endtask

    task automatic do_reset();
        int saved;
        saved    = rdy_mode;
        rdy_mode = 1;
        repeat (4) cyc();
        check_eq("drain_before_reset", exp_q.size(), 0);
        rst    = 1'b1;
        m_open = 1'b0;
        cyc();
        @(negedge clk);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_out_data", pack_blk(out_iaddr, out_iretire, out_itype, out_priv,
                                            out_ilastsize, out_cause, out_tval), '0);
        cyc();
        rst      = 1'b0;
        rdy_mode = saved;
    endtask

    logic [ITYPE_LEN-1:0] term_types [5] = '{ItypeExc, ItypeInt, ItypeTb, ItypeRet, ItypeNtb};

    initial begin
        exc_info_s  ne;
        uop_entry_s inv;
        uop_entry_s ln [2];
        int         nv;
        int         r;
        logic [PRIV_LEN-1:0] cur_priv;

        ne        = mk_exc('0, '0);
        inv       = mk(1'b0, '0, ItypeStd, '0, 1'b0);
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_uop    = '0;
        in_exc    = '0;
        cur_priv  = 2'd3;

        repeat (2) cyc();
        @(negedge clk);
        check_eq("reset_valid", out_valid, 0);
        check_eq("reset_in_ready", in_ready, 0);
        check_eq("reset_outputs", pack_blk(out_iaddr, out_iretire, out_itype, out_priv,
                                           out_ilastsize, out_cause, out_tval), '0);
        cyc();
        rst = 1'b0;
        cyc();

        // Two-lane beat closed by a taken branch; one-cycle output latency.
        drive_beat(mk(1, 32'h100, ItypeStd, 3, 0), mk(1, 32'h104, ItypeTb, 3, 0), ne);
        @(negedge clk);
        check_eq("t1_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_latency", out_valid, 1);
        cyc();

        // Two terminating lanes: two blocks over two cycles.
        drive_beat(mk(1, 32'h200, ItypeTb, 3, 0), mk(1, 32'h300, ItypeRet, 3, 1), ne);
        @(negedge clk);
        check_eq("t2_in_ready_c1", in_ready, 0);
        cyc();
        @(negedge clk);
        check_eq("t2_in_ready_c2", in_ready, 1);
        cyc();
        in_valid = 1'b0;

        // Privilege change splits the open block.
        send(mk(1, 32'h400, ItypeStd, 3, 0), inv, ne, "t3a");
        send(mk(1, 32'h404, ItypeStd, 0, 0), inv, ne, "t3b");
        send(mk(1, 32'h408, ItypeTb, 0, 1), inv, ne, "t3c");

        // Counter saturation: 8th non-compressed lane would exceed 15.
        for (int i = 0; i < 4; i++)
            send(mk(1, 32'h1000 + 8 * i, ItypeStd, 3, 0),
                 mk(1, 32'h1004 + 8 * i, ItypeStd, 3, 0), ne, "t4");
        do_flush();

        // Zero-lane beat is accepted at once.
        drive_beat(inv, inv, ne);
        @(negedge clk);
        check_eq("zero_beat_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;

        // Exception while the output is backpressured.
        repeat (2) cyc();
        rdy_mode = 2;
        cyc();
        send(mk(1, 32'h480, ItypeTb, 3, 0), inv, ne, "t5a");
        drive_beat(mk(1, 32'h500, ItypeExc, 3, 0), inv, mk_exc(32'h2, 32'hdead));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t5_stall_in_ready", in_ready, 0);
            cyc();
        end
        rdy_mode = 1;
        wait_accept("t5b");

        // Flush of a 6-halfword block, then reset with a block open.
        send(mk(1, 32'h600, ItypeStd, 3, 0), mk(1, 32'h604, ItypeStd, 3, 0), ne, "t6a");
        send(mk(1, 32'h608, ItypeStd, 3, 0), inv, ne, "t6b");
        do_flush();
        send(mk(1, 32'h700, ItypeStd, 3, 0), inv, ne, "t6c");
        do_reset();
        send(mk(1, 32'h800, ItypeTb, 3, 0), inv, ne, "t6d");

        // Randomized traffic with backpressure, flushes and resets.
        rdy_mode = 0;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                do_flush();
            end else if (r < 5) begin
                do_reset();
            end else begin
                nv = $urandom_range(0, 2);
                for (int l = 0; l < 2; l++) begin
                    if ($urandom_range(0, 9) == 0) cur_priv = PRIV_LEN'($urandom_range(0, 3));
                    ln[l] = mk(l < nv, {$urandom, 1'b0} >> 1, ItypeStd, cur_priv,
                               1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 9) < 3) ln[l].itype = term_types[$urandom_range(0, 4)];
                end
                send(ln[0], ln[1], mk_exc($urandom, $urandom), "rand");
            end
        end

        rdy_mode = 1;
        do_flush();
        repeat (5) cyc();
        check_eq("final_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/te_block_aggregator.md
Name: te_block_aggregator

Overview:
- Next-generation retirement aggregator for the trace-encoder connector.
- Takes up to NRET retired uops per cycle (uop_entry_s lanes) and merges runs of STD instructions into instruction blocks.
- Each output block carries start address, iretire count in halfwords, terminating itype, privilege and exception info.
- Sits between the uop FIFO and the encoder's packet stage. Unlike the single-lane IDLE/COUNT counter, it handles multi-lane beats, privilege-change splits, counter saturation, flush and output backpressure.

Parameters:
- NRET, 2, number of uop lanes per input beat (1..8).
- XLEN, connector_pkg::XLEN, address/cause/tval width.
- IRETIRE_LEN, connector_pkg::IRETIRE_LEN, iretire counter width (legal 4..32).
- ITYPE_LEN, connector_pkg::ITYPE_LEN, itype width.
- PRIV_LEN, connector_pkg::PRIV_LEN, privilege width.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  beat fully consumed this cycle (combinational, depends on out_ready_i).
- in_uop_i  in  NRET x uop_entry_s  lanes; valid bits contiguous from lane 0.
- in_exc_i  in  exc_info_s  cause/tval for the EXC/INT lane of the beat.
- flush_i  in  1  force-close the open block.
- out_valid_o  out  1  block valid.
- out_ready_i  in  1  consumer accepts block.
- out_iaddr_o  out  XLEN  pc of first instruction in block.
- out_iretire_o  out  IRETIRE_LEN  block size in halfwords.
- out_itype_o  out  ITYPE_LEN  itype of last instruction, or STD if split.
- out_priv_o  out  PRIV_LEN  block privilege.
- out_ilastsize_o  out  1  last instruction compressed.
- out_cause_o  out  XLEN  cause if itype EXC/INT, else 0.
- out_tval_o  out  XLEN  tval if itype EXC/INT, else 0.

Behaviour:
- Reset: all outputs 0, state IDLE, lane pointer lp=0, count=0, block regs 0.
- Clock and reset: one clock; reset is synchronous and active-high.
- State machine: IDLE means no open block; COUNT means a block is open (iaddr, priv and count held).
- Lane increment inc = 1 if compressed, else 2.
- Output slot free: out_valid_o==0, or out_ready_i==1 in this cycle.
- At most one block is emitted per cycle, into a registered output: 1-cycle latency from the closing lane.
- Each cycle with in_valid_i && !flush_i, scan valid lanes from lp and stop at the first event lane k:
  - (a) Terminating itype (itype != STD): lane k is included in the block. Emit it, go to IDLE, lp=k+1.
  - (b) Split: state COUNT and priv != block priv, or count+inc > 2^IRETIRE_LEN-1. Emit the open block without lane k, itype STD, ilastsize from the previous lane. Go to IDLE with lp=k; lane k opens a new block next cycle.
  - (c) No event: every scanned lane is added to count; the first lane opens the block if in IDLE. State COUNT, lp=0.
- A lane in IDLE opens the block (iaddr=pc, priv, count=inc). If that lane is also terminating, it is emitted as a single-instruction block in the same cycle.
- If an event is found but the output slot is not free: no state change, nothing consumed, in_ready_o=0.
- in_ready_o=1 only when the scan this cycle consumes the last valid lane of the beat; lp then returns to 0.
- A beat with zero valid lanes is accepted immediately with no effect.
- Output hold: while out_valid_o && !out_ready_i, all out_* are held stable.
- flush_i has priority over input and forces in_ready_o=0:
  - COUNT with slot free: emit open block with itype STD, go to IDLE, lp kept.
  - IDLE: no-op.
- Exception info: cause/tval are latched from in_exc_i only for EXC/INT blocks; otherwise 0.
- Reset mid-block discards the open block and any pending output.

Decomposition:
- connector_pkg gains:
  - block_entry_s (iaddr, iretire, itype, priv, ilastsize, exc_info_s);
  - agg_state_e (IDLE, COUNT), so the existing state_e stays untouched;
  - function iretire_inc(compressed).
- Sub-module te_lane_scanner (combinational): from lanes, lp, block priv, count and state, produces event lane k, event kind, summed increment and last-lane flag.

Test Plan:
- NRET=2, beat {0x100 STD c=0, 0x104 TB c=0}, out_ready=1 -> next cycle out iaddr 0x100, iretire 4, itype TB; in_ready 1 in the accept cycle.
- Beat {0x200 TB c=0, 0x300 RET c=1} -> cycle 1: emit 0x200/2/TB, in_ready 0. Cycle 2: emit 0x300/1/RET, in_ready 1.
- Open block 0x400 priv 3 (1 STD), next lane 0x404 priv 0 STD -> emit 0x400/2/STD priv 3. Following cycle opens block 0x404 priv 0.
- IRETIRE_LEN=4: 7 STD c=0 lanes (count 14), 8th STD c=0 -> emit count 14 itype STD; 8th lane starts a new block with count 2.
- EXC lane at 0x500 with cause 0x2, tval 0xdead, while out_ready held 0 with an output pending -> in_ready 0 and out stable. After release: out itype EXC, cause 2, tval 0xdead.
- flush_i in COUNT (block 0x600, count 6) -> emit 0x600/6/STD. Then rst_i mid-block with a new open block -> out_valid 0, next beat opens a fresh block.
